// File: rtl/ifetcher.sv
// ifetcher: instruction fetch unit with a 4-entry issue queue and a 64-entry 2-bit BHT.
// Keeps at most one instruction-read request outstanding and redirects on ROB_clear.
module ifetcher (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_valid,
    input  logic [31:0] MC_data,
    output logic        IS_ins_sgn,
    output logic [31:0] IS_ins,
    output logic        IS_jump_flag,
    output logic [31:0] IS_jump_pc,
    input  logic        IS_stall,
    input  logic        ROB_clear,
    input  logic [31:0] ROB_newpc,
    input  logic        ROB_br_sgn,
    input  logic [31:0] ROB_br_pc,
    input  logic        ROB_br_taken
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_mc_req;
    logic [31:0] r_mc_addr;
    logic [1:0]  r_bht [64];
    logic [31:0] r_q_ins [4];
    logic [31:0] r_q_jpc [4];
    logic        r_q_flag [4];
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [2:0]  r_count;
    logic        r_is_sgn;
    logic [31:0] r_is_ins;
    logic        r_is_flag;
    logic [31:0] r_is_jpc;

    logic [6:0]  w_op;
    logic [31:0] w_jimm;
    logic [31:0] w_bimm;
    logic [31:0] w_pc4;
    logic [31:0] w_pc_j;
    logic [31:0] w_pc_b;
    logic        w_pred;
    logic        w_flag;
    logic [31:0] w_npc;
    logic [31:0] w_jpc;
    logic        w_push;
    logic        w_pop;
    logic        w_start;
    logic [1:0]  w_bht_cur;
    logic [1:0]  w_bht_nxt;
    logic        w_unused;

    assign w_op   = MC_data[6:0];
    assign w_jimm = {{12{MC_data[31]}}, MC_data[19:12], MC_data[20], MC_data[30:21], 1'b0};
    assign w_bimm = {{20{MC_data[31]}}, MC_data[7], MC_data[30:25], MC_data[11:8], 1'b0};
    assign w_pc4  = r_pc + 32'd4;
    assign w_pc_j = r_pc + w_jimm;
    assign w_pc_b = r_pc + w_bimm;
    assign w_pred = r_bht[r_pc[7:2]][1];
    assign w_flag = (w_op == OP_BR) && w_pred;
    assign w_npc  = (w_op == OP_JAL) ? w_pc_j : w_flag ? w_pc_b : w_pc4;
    assign w_jpc  = (w_op == OP_BR) ? (w_pred ? w_pc4 : w_pc_b) : (w_op == OP_AUIPC) ? r_pc : w_pc4;

    assign w_push  = rdy && !ROB_clear && (r_state == S_WAIT) && MC_valid;
    assign w_pop   = rdy && !ROB_clear && (r_count != 3'd0) && !IS_stall;
    assign w_start = rdy && !ROB_clear && (r_state == S_FETCH) && (r_count < 3'd4);

    assign w_bht_cur = r_bht[ROB_br_pc[7:2]];
    assign w_bht_nxt = ROB_br_taken ? ((w_bht_cur == 2'd3) ? 2'd3 : w_bht_cur + 2'd1)
                                    : ((w_bht_cur == 2'd0) ? 2'd0 : w_bht_cur - 2'd1);
    assign w_unused  = ^{ROB_br_pc[31:8], ROB_br_pc[1:0]};

    assign MC_req       = r_mc_req;
    assign MC_addr      = r_mc_addr;
    assign IS_ins_sgn   = r_is_sgn;
    assign IS_ins       = r_is_ins;
    assign IS_jump_flag = r_is_flag;
    assign IS_jump_pc   = r_is_jpc;

    // fetch control: a clear wins over push, pop and the opcode-driven redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= 32'd0;
            r_mc_req  <= 1'b0;
            r_mc_addr <= 32'd0;
            r_head    <= 2'd0;
            r_tail    <= 2'd0;
            r_count   <= 3'd0;
        end else if (rdy) begin
            if (ROB_clear) begin
                r_state  <= S_FETCH;
                r_pc     <= ROB_newpc;
                r_mc_req <= 1'b0;
                r_head   <= 2'd0;
                r_tail   <= 2'd0;
                r_count  <= 3'd0;
            end else begin
                if (w_start) begin
                    r_state   <= S_WAIT;
                    r_mc_req  <= 1'b1;
                    r_mc_addr <= r_pc;
                end
                if (w_push) begin
                    r_state  <= (w_op == OP_JALR) ? S_HOLD : S_FETCH;
                    r_pc     <= w_npc;
                    r_mc_req <= 1'b0;
                    r_tail   <= r_tail + 2'd1;
                end
                if (w_pop)
                    r_head <= r_head + 2'd1;
                r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_ins[r_tail]  <= MC_data;
            r_q_jpc[r_tail]  <= w_jpc;
            r_q_flag[r_tail] <= w_flag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_sgn  <= 1'b0;
            r_is_ins  <= 32'd0;
            r_is_flag <= 1'b0;
            r_is_jpc  <= 32'd0;
        end else begin
            r_is_sgn <= w_pop;
            if (w_pop) begin
                r_is_ins  <= r_q_ins[r_head];
                r_is_flag <= r_q_flag[r_head];
                r_is_jpc  <= r_q_jpc[r_head];
            end
        end
    end

    // predictor update is not blocked by a clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++)
                r_bht[i] <= 2'b01;
        end else if (rdy && ROB_br_sgn) begin
            r_bht[ROB_br_pc[7:2]] <= w_bht_nxt;
        end
    end
endmodule

// File: tb/tb_ifetcher.sv
// tb_ifetcher: table-driven fetch vectors plus directed corner sequences, checked through an issue scoreboard.
module tb_ifetcher;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_valid = 1'b0;
    logic [31:0] MC_data = 32'd0;
    logic        IS_ins_sgn;
    logic [31:0] IS_ins;
    logic        IS_jump_flag;
    logic [31:0] IS_jump_pc;
    logic        IS_stall = 1'b0;
    logic        ROB_clear = 1'b0;
    logic [31:0] ROB_newpc = 32'd0;
    logic        ROB_br_sgn = 1'b0;
    logic [31:0] ROB_br_pc = 32'd0;
    logic        ROB_br_taken = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] ins; logic flag; logic [31:0] jpc; } exp_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; logic flag; logic [31:0] jpc; logic [31:0] nxt; } vec_t;
    exp_t sb[$];
    vec_t vt [8];

    ifetcher dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .MC_req(MC_req), .MC_addr(MC_addr), .MC_valid(MC_valid), .MC_data(MC_data),
        .IS_ins_sgn(IS_ins_sgn), .IS_ins(IS_ins), .IS_jump_flag(IS_jump_flag), .IS_jump_pc(IS_jump_pc),
        .IS_stall(IS_stall), .ROB_clear(ROB_clear), .ROB_newpc(ROB_newpc),
        .ROB_br_sgn(ROB_br_sgn), .ROB_br_pc(ROB_br_pc), .ROB_br_taken(ROB_br_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && IS_ins_sgn === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", IS_ins, 32'hxxxxxxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("is_ins", IS_ins, e.ins);
                chk("is_flag", 32'(IS_jump_flag), 32'(e.flag));
                chk("is_jpc", IS_jump_pc, e.jpc);
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (MC_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("req_timeout", 32'(MC_req), 32'd1);
    endtask

    task automatic clear_to(input logic [31:0] a);
        ROB_clear = 1'b1;
        ROB_newpc = a;
        @(negedge clk);
        ROB_clear = 1'b0;
        chk("clear_req_low", 32'(MC_req), 32'd0);
        chk("clear_no_issue", 32'(IS_ins_sgn), 32'd0);
    endtask

    task automatic serve(input logic [31:0] a, input logic [31:0] ins, input logic fl, input logic [31:0] jpc, input int lat);
        wait_req();
        chk("mc_addr", MC_addr, a);
        repeat (lat) @(negedge clk);
        chk("mc_addr_stable", MC_addr, a);
        MC_valid = 1'b1;
        MC_data = ins;
        sb.push_back('{ins, fl, jpc});
        @(negedge clk);
        MC_valid = 1'b0;
        MC_data = $urandom;
    endtask

    task automatic fetch_one(input logic do_clr, input logic [31:0] a, input logic [31:0] ins, input logic fl,
                             input logic [31:0] jpc, input logic [31:0] nxt, input int lat);
        if (do_clr) clear_to(a);
        serve(a, ins, fl, jpc, lat);
        chk("latency_t1", 32'(IS_ins_sgn), 32'd0);
        @(negedge clk);
        chk("latency_t2", 32'(IS_ins_sgn), 32'd1);
        chk("next_req", 32'(MC_req), 32'd1);
        chk("next_addr", MC_addr, nxt);
    endtask

    task automatic bht(input logic [31:0] pc, input logic tk);
        ROB_br_sgn = 1'b1;
        ROB_br_pc = pc;
        ROB_br_taken = tk;
        @(negedge clk);
        ROB_br_sgn = 1'b0;
    endtask

    initial begin
        vt[0] = '{32'h00000000, 32'h00500093, 1'b0, 32'h00000004, 32'h00000004};
        vt[1] = '{32'h00000008, 32'h0100006F, 1'b0, 32'h0000000C, 32'h00000018};
        vt[2] = '{32'h00000008, 32'h1000006F, 1'b0, 32'h0000000C, 32'h00000108};
        vt[3] = '{32'h00000020, 32'h00000863, 1'b0, 32'h00000030, 32'h00000024};
        vt[4] = '{32'h00000104, 32'hFE001CE3, 1'b0, 32'h000000FC, 32'h00000108};
        vt[5] = '{32'h00000050, 32'h12345097, 1'b0, 32'h00000050, 32'h00000054};
        vt[6] = '{32'h00000010, 32'hFFDFF06F, 1'b0, 32'h00000014, 32'h0000000C};
        vt[7] = '{32'hFFFFFFF8, 32'h0100006F, 1'b0, 32'hFFFFFFFC, 32'h00000008};
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(MC_req), 32'd0);
        chk("rst_addr", MC_addr, 32'd0);
        chk("rst_sgn", 32'(IS_ins_sgn), 32'd0);
        chk("rst_ins", IS_ins, 32'd0);
        chk("rst_flag", 32'(IS_jump_flag), 32'd0);
        chk("rst_jpc", IS_jump_pc, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++)
            fetch_one(i != 0, vt[i].pc, vt[i].ins, vt[i].flag, vt[i].jpc, vt[i].nxt, i % 3 + 1);

        bht(32'h20, 1'b1);
        bht(32'h20, 1'b1);
        fetch_one(1'b1, 32'h20, 32'h00000863, 1'b1, 32'h24, 32'h30, 2);
        repeat (4) bht(32'h20, 1'b0);
        repeat (2) bht(32'h20, 1'b1);
        fetch_one(1'b1, 32'h20, 32'h00000863, 1'b1, 32'h24, 32'h30, 1);
        bht(32'h20, 1'b0);
        fetch_one(1'b1, 32'h20, 32'h00000863, 1'b0, 32'h30, 32'h24, 1);

        clear_to(32'h20);
        wait_req();
        MC_valid = 1'b1;
        MC_data = 32'h00000863;
        ROB_br_sgn = 1'b1;
        ROB_br_pc = 32'h20;
        ROB_br_taken = 1'b1;
        sb.push_back('{32'h00000863, 1'b0, 32'h30});
        @(negedge clk);
        MC_valid = 1'b0;
        ROB_br_sgn = 1'b0;
        @(negedge clk);
        chk("preupd_next_addr", MC_addr, 32'h24);
        fetch_one(1'b1, 32'h20, 32'h00000863, 1'b1, 32'h24, 32'h30, 1);

        clear_to(32'h300);
        IS_stall = 1'b1;
        for (int k = 0; k < 4; k++)
            serve(32'h300 + 32'(4 * k), (32'(k + 1) << 20) | 32'h93, 1'b0, 32'h304 + 32'(4 * k), 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("full_no_req", 32'(MC_req), 32'd0);
            chk("stall_no_issue", 32'(IS_ins_sgn), 32'd0);
        end
        IS_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_pulse", 32'(IS_ins_sgn), 32'd1);
        end
        @(negedge clk);
        chk("drain_done", 32'(IS_ins_sgn), 32'd0);
        fetch_one(1'b0, 32'h310, 32'h00500093, 1'b0, 32'h314, 32'h314, 1);

        clear_to(32'h40);
        serve(32'h40, 32'h00008067, 1'b0, 32'h44, 2);
        @(negedge clk);
        chk("jalr_issue", 32'(IS_ins_sgn), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("hold_no_req", 32'(MC_req), 32'd0);
        end
        fetch_one(1'b1, 32'h200, 32'h00500093, 1'b0, 32'h204, 32'h204, 1);

        clear_to(32'h400);
        IS_stall = 1'b1;
        serve(32'h400, 32'h00100093, 1'b0, 32'h404, 1);
        serve(32'h404, 32'h00200093, 1'b0, 32'h408, 1);
        wait_req();
        chk("clr_addr", MC_addr, 32'h408);
        MC_valid = 1'b1;
        MC_data = 32'h00300093;
        ROB_clear = 1'b1;
        ROB_newpc = 32'h500;
        sb.delete();
        @(negedge clk);
        MC_valid = 1'b0;
        ROB_clear = 1'b0;
        IS_stall = 1'b0;
        chk("clr_valid_no_issue", 32'(IS_ins_sgn), 32'd0);
        chk("clr_valid_req_low", 32'(MC_req), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("flushed_no_issue", 32'(IS_ins_sgn), 32'd0);
        end
        fetch_one(1'b0, 32'h500, 32'h00500093, 1'b0, 32'h504, 32'h504, 1);

        clear_to(32'h600);
        wait_req();
        rdy = 1'b0;
        MC_valid = 1'b1;
        MC_data = 32'h00000863;
        ROB_br_sgn = 1'b1;
        ROB_br_pc = 32'h20;
        ROB_br_taken = 1'b0;
        @(negedge clk);
        MC_valid = 1'b0;
        ROB_br_sgn = 1'b0;
        repeat (3) begin
            chk("rdy_req_hold", 32'(MC_req), 32'd1);
            chk("rdy_addr_hold", MC_addr, 32'h600);
            chk("rdy_no_issue", 32'(IS_ins_sgn), 32'd0);
            @(negedge clk);
        end
        rdy = 1'b1;
        fetch_one(1'b0, 32'h600, 32'h00700093, 1'b0, 32'h604, 32'h604, 1);
        fetch_one(1'b1, 32'h20, 32'h00000863, 1'b1, 32'h24, 32'h30, 1);

        clear_to(32'h700);
        wait_req();
        rdy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_req", 32'(MC_req), 32'd0);
        chk("rst2_addr", MC_addr, 32'd0);
        chk("rst2_ins", IS_ins, 32'd0);
        chk("rst2_flag", 32'(IS_jump_flag), 32'd0);
        chk("rst2_jpc", IS_jump_pc, 32'd0);
        rst = 1'b0;
        rdy = 1'b1;
        sb.delete();
        fetch_one(1'b0, 32'h0, 32'h00500093, 1'b0, 32'h4, 32'h4, 1);
        fetch_one(1'b1, 32'h20, 32'h00000863, 1'b0, 32'h30, 32'h24, 1);
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
